instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/fetch_buf.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants.
// Holds the reset PC, NOP encoding, opcodes and fetch FSM encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] pc
  );
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of {pc, inst} entries.
// Flush wins over push and pop; push into a full FIFO is legal alongside a pop.
module fetch_buf
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues word fetches, buffers responses with their PC,
// and discards in-flight responses after a redirect.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] discard_nxt;
  logic [CW-1:0] buf_count;
  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          rsp_take;
  logic          pop;
  logic          push;
  logic          buf_empty;
  logic          buf_full;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  // Responses with nothing outstanding are stale (e.g. issued before reset).
  assign rsp_take  = imem_rsp_valid && (outstanding != '0);
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign pop       = inst_valid && inst_ready;
  assign push      = (state == ST_FETCH) && rsp_take
                     && !redirect_valid && (!buf_full || pop);
  assign push_data = '{pc: '0, inst: imem_rsp_data};

  // A slot freed by this cycle's pop is already available to a new request.
  assign occupancy = {1'b0, outstanding} + {1'b0, buf_count}
                     - (CW + 1)'(pop);

  always_comb begin
    discard_nxt = discard;
    if (state == ST_DRAIN)
      discard_nxt = discard - CW'(rsp_take);
    else if (redirect_valid)
      discard_nxt = outstanding - CW'(rsp_take);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (redirect_valid && discard_nxt != '0)
                  state_nxt = ST_DRAIN;
      ST_DRAIN: if (discard_nxt == '0)
                  state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    if (state == ST_FETCH && !redirect_valid && occupancy < DEPTH_W)
      imem_req_valid = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      discard     <= discard_nxt;
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      if (redirect_valid)
        fetch_pc <= align_pc(redirect_pc);
      else if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // PC of each buffered word is tracked by a parallel PC FIFO below.
  logic [31:0] pc_q [BUF_DEPTH];
  logic [31:0] rsp_pc;
  logic [$clog2(BUF_DEPTH > 1 ? BUF_DEPTH : 2)-1:0] pc_wr;
  logic [$clog2(BUF_DEPTH > 1 ? BUF_DEPTH : 2)-1:0] pc_rd;
  logic [31:0] req_pc_q [BUF_DEPTH];

  assign rsp_pc = req_pc_q[pc_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_wr <= '0;
      pc_rd <= '0;
    end else begin
      if (req_fire)
        pc_wr <= (32'(pc_wr) == BUF_DEPTH - 1) ? '0 : pc_wr + 1'b1;
      if (rsp_take)
        pc_rd <= (32'(pc_rd) == BUF_DEPTH - 1) ? '0 : pc_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) req_pc_q[pc_wr] <= fetch_pc;
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{pc: rsp_pc, inst: push_data.inst}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign imem_req_addr = fetch_pc;
  assign inst_valid    = !buf_empty;
  assign inst          = buf_empty ? NOP : head.inst;
  assign inst_pc       = buf_empty ? '0 : head.pc;
  assign opcode        = inst[6:0];
  assign funct3        = inst[14:12];
  assign funct7        = inst[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, corner sequences,
// and random traffic against a program-order reference model.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
    int          gen;
  } mreq_t;

  typedef struct {
    bit          rdy;
    bit          rv;
    bit          irdy;
    logic [31:0] rd;
    bit          e_rv;
    logic [31:0] e_ra;
    bit          e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
  } vec_t;

  mreq_t       memq[$];
  vec_t        tbl[6];
  int          gen = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          delivered = 0;
  int          req_cnt = 0;
  logic [31:0] exp_pc;
  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_inst_valid;
  logic [31:0] s_inst_pc;
  logic [31:0] s_inst;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mkdata(
    input logic [31:0] a,
    input int          g
  );
    return (a * 32'h9E37_79B1) ^ (32'(g) * 32'h0101_0101) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input bit keep);
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    gen++;
    if (!keep) memq.delete();
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RESET_PC_DEFAULT);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = RESET_PC_DEFAULT;
    prev_stall = 1'b0;
  endtask

  // One clock: memory model drives in-order responses, the model checks
  // every delivered instruction against program order.
  task automatic cycle(
    input bit          rdy,
    input bit          irdy,
    input bit          redir,
    input logic [31:0] rpc,
    input int unsigned lat
  );
    int live;
    imem_req_ready = rdy;
    inst_ready     = irdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].data;
      void'(memq.pop_front());
    end
    #2;
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_inst_valid = inst_valid;
    s_inst_pc    = inst_pc;
    s_inst       = inst;
    if (prev_stall && !redir) begin
      chk("req_hold_valid", imem_req_valid, 1);
      chk("req_hold_addr", imem_req_addr, prev_addr);
    end
    if (redir) chk("redirect_withdraw", imem_req_valid, 0);
    if (imem_req_valid && rdy) begin
      memq.push_back('{mkdata(imem_req_addr, gen), cyc + lat, gen});
      req_cnt++;
    end
    prev_stall = imem_req_valid && !rdy;
    prev_addr  = imem_req_addr;
    if (inst_valid && irdy) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_word", inst, mkdata(exp_pc, gen));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (!inst_valid) begin
      chk("empty_nop", inst, NOP);
      chk("empty_pc", inst_pc, 0);
    end
    if (redir) exp_pc = rpc & ~32'h3;
    live = 0;
    foreach (memq[i]) if (memq[i].gen == gen) live++;
    chk("inflight_bound", 32'(live <= DEPTH), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          rd;
    bit          ir;
    bit          rv;
    int          d0;

    tbl[0] = '{1, 0, 1, 32'h0, 0, 32'h00, 0, 32'h0, NOP,
               7'h13, 3'h0, 7'h00};
    tbl[1] = '{1, 0, 1, 32'h0, 1, 32'h00, 0, 32'h0, NOP,
               7'h13, 3'h0, 7'h00};
    tbl[2] = '{1, 1, 1, 32'h0050_0093, 1, 32'h04, 0, 32'h0, NOP,
               7'h13, 3'h0, 7'h00};
    tbl[3] = '{1, 1, 1, 32'h4020_81B3, 1, 32'h08, 1, 32'h0,
               32'h0050_0093, 7'h13, 3'h0, 7'h00};
    tbl[4] = '{1, 1, 1, 32'h0020_C233, 1, 32'h0C, 1, 32'h4,
               32'h4020_81B3, 7'h33, 3'h0, 7'h20};
    tbl[5] = '{1, 0, 0, 32'h0, 0, 32'h10, 1, 32'h8,
               32'h0020_C233, 7'h33, 3'h4, 7'h00};

    #1;
    do_reset(0);

    // Back-to-back fetch with a 1-cycle memory.
    for (int i = 0; i < 6; i++) begin
      imem_req_ready = tbl[i].rdy;
      imem_rsp_valid = tbl[i].rv;
      imem_rsp_data  = tbl[i].rd;
      inst_ready     = tbl[i].irdy;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      #2;
      chk($sformatf("vec%0d_req_valid", i), imem_req_valid, tbl[i].e_rv);
      chk($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].e_ra);
      chk($sformatf("vec%0d_inst_valid", i), inst_valid, tbl[i].e_iv);
      chk($sformatf("vec%0d_inst_pc", i), inst_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_inst", i), inst, tbl[i].e_inst);
      chk($sformatf("vec%0d_opcode", i), opcode, tbl[i].e_op);
      chk($sformatf("vec%0d_funct3", i), funct3, tbl[i].e_f3);
      chk($sformatf("vec%0d_funct7", i), funct7, tbl[i].e_f7);
      @(posedge clk);
      #1;
    end

    // Decode stalled: fetch fills and stops, nothing lost on release.
    do_reset(0);
    req_cnt = 0;
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 1);
    chk("stall_req_count", req_cnt, DEPTH);
    chk("stall_req_valid", s_req_valid, 0);
    chk("stall_inst_valid", s_inst_valid, 1);
    delivered = 0;
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, 1);
    chk("stall_release_flow", 32'(delivered >= 4), 1);

    // Redirect with two responses in flight at 3-cycle latency.
    do_reset(0);
    cycle(1, 1, 0, 0, 3);
    cycle(1, 1, 0, 0, 3);
    cycle(1, 1, 0, 0, 3);
    chk("drain_setup_addr", s_req_addr, 32'h4);
    cycle(1, 1, 1, 32'h100, 3);
    cycle(1, 1, 0, 0, 3);
    chk("drain_req_off1", s_req_valid, 0);
    chk("drain_inst_off1", s_inst_valid, 0);
    cycle(1, 1, 0, 0, 3);
    chk("drain_req_off2", s_req_valid, 0);
    chk("drain_inst_off2", s_inst_valid, 0);
    cycle(1, 1, 0, 0, 3);
    chk("drain_next_valid", s_req_valid, 1);
    chk("drain_next_addr", s_req_addr, 32'h100);
    delivered = 0;
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 3);
    chk("drain_target_flow", 32'(delivered > 0), 1);

    // Redirect together with a response and an inst handshake.
    do_reset(0);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 1, 32'h40, 1);
    chk("coinc_hs_valid", s_inst_valid, 1);
    chk("coinc_hs_pc", s_inst_pc, 32'h0);
    cycle(1, 1, 0, 0, 1);
    chk("coinc_empty_valid", s_inst_valid, 0);
    chk("coinc_empty_inst", s_inst, NOP);
    chk("coinc_empty_pc", s_inst_pc, 32'h0);
    chk("coinc_next_addr", s_req_addr, 32'h40);

    // Address wrap and redirect alignment.
    do_reset(0);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 1, 32'hFFFF_FFFC, 1);
    cycle(1, 1, 0, 0, 1);
    chk("wrap_top_addr", s_req_addr, 32'hFFFF_FFFC);
    cycle(1, 1, 0, 0, 1);
    chk("wrap_zero_valid", s_req_valid, 1);
    chk("wrap_zero_addr", s_req_addr, 32'h0);
    cycle(1, 1, 1, 32'h203, 1);
    cycle(1, 1, 0, 0, 1);
    chk("align_addr", s_req_addr, 32'h200);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 1);

    // Reset with a stalled request and a response still in flight.
    do_reset(0);
    cycle(1, 1, 0, 0, 6);
    cycle(1, 1, 0, 0, 6);
    cycle(0, 1, 0, 0, 6);
    cycle(0, 1, 0, 0, 6);
    chk("late_setup_stalled", s_req_valid, 1);
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 0, 1);
      chk("late_rsp_ignored", s_inst_valid, 0);
    end
    delivered = 0;
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 1);
    chk("late_restart_flow", 32'(delivered > 0), 1);

    // Random traffic.
    do_reset(0);
    delivered = 0;
    for (int i = 0; i < 4000; i++) begin
      rd = ($urandom_range(0, 3) != 0);
      ir = ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 299) == 0) do_reset(0);
      cycle(rd, ir, rv, $urandom, $urandom_range(1, 4));
    end
    chk("random_flow", 32'(delivered > 100), 1);

    d0 = delivered;
    for (int k = 0; k < 50 && delivered == d0; k++)
      cycle(1, 1, 0, 0, 1);
    chk("final_liveness", 32'(delivered > d0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
